// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM arbiter slice.
// Holds port tags and the read-pipeline entry type.
package sram_pkg;

  localparam int SRAM_ADDR_W   = 20;
  localparam int SRAM_READ_LAT = 2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic tag;
  } rd_entry_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// One requester port of the SRAM arbiter.
// master: requester side; slave: arbiter side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              grant;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata,
    input  grant, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output grant, rvalid, rdata
  );

endinterface

// File: rtl/sram_read_tracker.sv
// DEPTH-deep valid/tag shift pipeline, synchronous clear.
// Ports: clk, rst, push (entry in), head (entry at depth DEPTH).
module sram_read_tracker
  import sram_pkg::*;
#(
  parameter int DEPTH = SRAM_READ_LAT
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_entry_t push,
  output rd_entry_t head
);

  rd_entry_t pipe_q [DEPTH];
  rd_entry_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = push;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign head = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: A priority, B anti-starvation.
// Ports: clk, rst, a_if/b_if (slave), sram_addr/we/wdata/rdata.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int READ_LAT = SRAM_READ_LAT,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     a_if,
  sram_arbiter_if.slave     b_if,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          force_b;
  logic          gnt_a, gnt_b;
  rd_entry_t     push, head;

  // B wins only once it has been denied MAX_WAIT cycles in a row.
  always_comb begin
    force_b = (wait_cnt_q == WW'(MAX_WAIT));
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    if (!rst) begin
      priority case (1'b1)
        force_b && b_if.req: gnt_b = 1'b1;
        a_if.req:            gnt_a = 1'b1;
        b_if.req:            gnt_b = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    sram_we   = 1'b0;
    sram_addr = '0;
    wdata_d   = wdata_q;
    if (gnt_a) begin
      sram_we   = a_if.we;
      sram_addr = a_if.addr;
      if (a_if.we) wdata_d = a_if.wdata;
    end else if (gnt_b) begin
      sram_we   = b_if.we;
      sram_addr = b_if.addr;
      if (b_if.we) wdata_d = b_if.wdata;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!b_if.req || gnt_b) begin
      wait_cnt_d = '0;
    end else if (!force_b) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      wdata_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wdata_q    <= wdata_d;
    end
  end

  assign push.valid = (gnt_a & ~a_if.we)
                    | (gnt_b & ~b_if.we);
  assign push.tag   = gnt_b ? PORT_B : PORT_A;

  sram_read_tracker #(
    .DEPTH (READ_LAT)
  ) u_trk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .head (head)
  );

  assign sram_wdata  = wdata_q;
  assign a_if.grant  = gnt_a;
  assign b_if.grant  = gnt_b;
  assign a_if.rvalid = head.valid && !rst
                    && (head.tag == PORT_A);
  assign b_if.rvalid = head.valid && !rst
                    && (head.tag == PORT_B);
  assign a_if.rdata  = sram_rdata;
  assign b_if.rdata  = sram_rdata;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM port between two requesters:
  - port A: the CPU memory stage (ldi/sti/ldr/fldi/fsti/fldr path). A has priority.
  - port B: the secondary master, i.e. the program loader / I/O DMA.
- Issues at most one SRAM access per cycle.
- Aligns write data to the SRAM's one-cycle-late write-data timing.
- Tracks in-flight reads through the fixed SRAM read latency and routes returned data to the requester that issued the read.
- A starvation counter guarantees port B progress under continuous CPU traffic.

Parameters:
- ADDR_W, 20: SRAM word-address width.
- READ_LAT, 2: cycles from address issue to valid sram_rdata.
- MAX_WAIT, 4: consecutive denied B-request cycles before B is forced ahead of A.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- a_req  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_W  port A address
- a_wdata  in  32  port A write data, sampled in the grant cycle
- a_grant  out  1  port A access issued this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  32  port A read data
- b_req, b_we, b_addr, b_wdata, b_grant, b_rvalid, b_rdata: same as port A, for port B
- sram_addr  out  ADDR_W  SRAM address
- sram_we  out  1  SRAM write enable, same cycle as address
- sram_wdata  out  32  SRAM write data, one cycle after address
- sram_rdata  in  32  SRAM read data, READ_LAT cycles after address

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Grant selection (combinational, cycle T):
  - force_b = (wait_cnt == MAX_WAIT).
  - If force_b && b_req, B is granted.
  - Otherwise, if a_req, A is granted.
  - Otherwise, if b_req, B is granted.
  - At most one grant is high.
- Issue (cycle T): sram_addr/sram_we come from the granted port. With no grant: sram_we=0, sram_addr=0.
- Write data: on a write grant, the granted port's wdata is registered and driven on sram_wdata in T+1. When no write is issued, sram_wdata holds its last value.
- Read tracking:
  - Each read grant pushes {valid=1, tag} into a READ_LAT-deep shift pipeline; tag is 0 for A, 1 for B.
  - At T+READ_LAT, the addressed port's rvalid pulses high for exactly one cycle.
  - Both a_rdata and b_rdata carry sram_rdata; only the tagged port's rvalid asserts.
  - Back-to-back reads, including alternating A/B, return in issue order with no bubbles.
- Mixed traffic: read-after-write and write-after-read are issued back-to-back with no stall. Order is preserved.
- Starvation counter wait_cnt (0..MAX_WAIT):
  - Increments when b_req && !b_grant, saturating at MAX_WAIT.
  - Clears to 0 on b_grant or when !b_req.
  - When A is denied because of force_b, A must hold a_req and its inputs until a_grant.
- Requester rule: request inputs must stay stable until grant. Dropping a request before grant is legal and cancels it.
- Reset (rst=1 at a clock edge) clears the following; all grants are suppressed while rst is high:
  - wait_cnt=0
  - pipeline valids=0
  - a_rvalid=b_rvalid=0
  - sram_wdata=0
- Reset mid-operation: in-flight reads are discarded, and no rvalid is produced for them after rst falls.
- Latencies: grant→SRAM address 0 cycles; grant→sram_wdata 1 cycle; grant→rvalid READ_LAT cycles.

Decomposition:
- Shared package sram_pkg:
  - SRAM_ADDR_W and SRAM_READ_LAT constants.
  - Port tag constants PORT_A=0, PORT_B=1.
  - Read pipeline entry typedef {valid, tag}.
- One sub-module, sram_read_tracker: the READ_LAT-deep valid/tag shift pipeline with synchronous clear. It outputs the tag and valid at depth READ_LAT.
- The arbiter top holds grant logic, wait_cnt, and the write-data register.

Test Plan:
- Single A read, addr 0x00010, SRAM model returns 0xDEADBEEF → a_grant at T; a_rvalid=1 with a_rdata=0xDEADBEEF at T+2; b_rvalid stays 0.
- A write, addr 0x00020, data 0x12345678 → sram_we=1 and sram_addr=0x00020 at T; sram_wdata=0x12345678 at T+1. A following read of 0x00020 returns 0x12345678.
- a_req and b_req both held continuously, reads → A is granted for 4 cycles, B at the 5th, then A resumes. Pattern AAAAB repeats; each rvalid arrives 2 cycles after its grant on the correct port.
- Alternating reads A@T, B@T+1, A@T+2 (addrs 1,2,3; model returns addr+0x100) → a_rvalid at T+2 (0x101), b_rvalid at T+3 (0x102), a_rvalid at T+4 (0x103).
- B alone, write 0x00FFF data 0xCAFEF00D while a_req=0 → b_grant same cycle; wait_cnt stays 0.
- Reads granted at T and T+1, rst asserted at T+1 for one cycle → no a_rvalid/b_rvalid at T+2 or T+3; wait_cnt=0 and sram_wdata=0 after reset.
